// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stall/flush enables, EX operand forwarding, multi-cycle dmem hold FSM.
// Latency: all control outputs combinational from inputs and FSM state; state/counters update on clk.
// Backpressure: a pending data-memory access freezes F/D/E/M and bubbles WB until dmem_ready or timeout.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic [1:0]       ResultSrcE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [7:0]       TIMEOUT = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [1:0]       FWD_RF  = 2'b00;
    localparam logic [1:0]       FWD_WB  = 2'b01;
    localparam logic [1:0]       FWD_MEM = 2'b10;

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic             lw_stall;
    logic             mem_hold;
    logic [1:0]       fwd_a, fwd_b;

    // Register x0 never forwards; the MEM stage holds the younger value so it wins.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                           input logic wr_m, input logic [4:0] rd_w,
                                           input logic wr_w);
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs))
            return FWD_MEM;
        else if (wr_w && (rd_w != 5'd0) && (rd_w == rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        mem_err_d      = mem_err_q;
        stall_cycles_d = stall_cycles_q;
        mem_hold       = 1'b0;
        dmem_req       = 1'b0;
        StallF         = 1'b0;
        StallD         = 1'b0;
        StallE         = 1'b0;
        StallM         = 1'b0;
        FlushD         = 1'b0;
        FlushE         = 1'b0;
        FlushW         = 1'b0;

        fwd_a    = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        fwd_b    = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
        lw_stall = (ResultSrcE == 2'b01) && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

        case (state_q)
            RUN: begin
                dmem_req = MemReqM;
                // A miss stalls in the same cycle it is seen, before the FSM has moved.
                if (MemReqM && !dmem_ready) begin
                    mem_hold   = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                dmem_req = 1'b1;
                mem_hold = 1'b1;
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                end else if (wait_cnt_q == TIMEOUT) begin
                    state_d    = RUN;
                    wait_cnt_d = 8'd0;
                    mem_err_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = RUN;
        endcase

        // Memory hold freezes EX, so a pending branch/load-use is replayed once RUN resumes.
        if (mem_hold) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushE = lw_stall | PCSrcE;
            FlushD = PCSrcE;
        end

        ForwardAE = fwd_a;
        ForwardBE = fwd_b;
        if (!rst_n) begin
            dmem_req  = 1'b0;
            StallF    = 1'b0;
            StallD    = 1'b0;
            StallE    = 1'b0;
            StallM    = 1'b0;
            FlushD    = 1'b0;
            FlushE    = 1'b0;
            FlushW    = 1'b0;
            ForwardAE = FWD_RF;
            ForwardBE = FWD_RF;
        end

        if (StallF && (stall_cycles_q != CNT_MAX))
            stall_cycles_d = stall_cycles_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            wait_cnt_q     <= 8'd0;
            mem_err_q      <= 1'b0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            mem_err_q      <= mem_err_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_cycles_q;

endmodule
